fetch_sequencer: RTL and testbench

- Sequences the program counter and instruction fetch for the multicycle MIPS core.
- Owns the PC register and issues word fetches to instruction memory over a req/ack handshake.
- Hands each fetched instruction to decode over a valid/ready handshake.
- Applies branch/jump redirects and exception vectoring, including squashing an in-flight fetch.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/fetch_sequencer.sv | 159 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg
//   Shared definitions for the multicycle MIPS core: datapath word width,
//   PC increment, default reset/exception vectors and the fetch sequencer
//   state encoding.
// ============================================================================
`default_nettype none

package mips_pkg;

   localparam int                WORD_W               = 32;
   localparam logic [WORD_W-1:0] PC_INCR              = 32'd4;
   localparam logic [WORD_W-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam logic [WORD_W-1:0] DEFAULT_EXC_VECTOR   = 32'h0000_0180;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      REQ   = 2'd1,
      ISSUE = 2'd2,
      DRAIN = 2'd3
   } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// fetch_sequencer
//   Owns the program counter, issues word fetches to instruction memory over
//   a req/ack handshake and presents each fetched word to decode over a
//   valid/ready handshake. Handles branch/jump redirects and exception
//   vectoring, including squashing a fetch that is already in flight.
//
//   Ports:
//     clock, reset_n             clock (rising edge), async active-low reset
//     imem_req/imem_addr         fetch request, address held until ack
//     imem_ack/imem_rdata        request accepted, instruction word
//     instr_valid/instr/instr_pc instruction offered to decode
//     dec_ready                  decode accepts the instruction
//     stall                      hazard hold, blocks hand-off to decode
//     redirect_valid/_target     taken branch/jump pulse and target
//     exception                  exception pulse, vectors to EXC_VECTOR
//     epc                        PC captured at the last exception
//     pc                         address of the next fetch
// ============================================================================
`default_nettype none

module fetch_sequencer
   import mips_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter logic [WORD_W-1:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR
) (
   input  logic              clock,
   input  logic              reset_n,
   output logic              imem_req,
   output logic [WORD_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [WORD_W-1:0] imem_rdata,
   output logic              instr_valid,
   output logic [WORD_W-1:0] instr,
   output logic [WORD_W-1:0] instr_pc,
   input  logic              dec_ready,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [WORD_W-1:0] redirect_target,
   input  logic              exception,
   output logic [WORD_W-1:0] epc,
   output logic [WORD_W-1:0] pc
);

   fetch_state_t      state, state_nxt;
   logic [WORD_W-1:0] pc_nxt, addr_nxt, instr_nxt, instr_pc_nxt, epc_nxt;
   logic              valid_nxt;

   logic              flow_change;
   logic [WORD_W-1:0] target;

   // Target alignment drops the byte-offset bits of the redirect.
   logic              unused_target_bits;
   assign unused_target_bits = ^redirect_target[1:0];

   // Exception outranks redirect; either one changes the flow.
   assign flow_change = exception | redirect_valid;
   assign target      = exception ? EXC_VECTOR : {redirect_target[WORD_W-1:2], 2'b00};

   // A request stays up in DRAIN too: it cannot be withdrawn once issued.
   assign imem_req = (state == REQ) || (state == DRAIN);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= BOOT;
         pc          <= RESET_VECTOR;
         imem_addr   <= '0;
         instr_valid <= 1'b0;
         instr       <= '0;
         instr_pc    <= '0;
         epc         <= '0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         imem_addr   <= addr_nxt;
         instr_valid <= valid_nxt;
         instr       <= instr_nxt;
         instr_pc    <= instr_pc_nxt;
         epc         <= epc_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      addr_nxt     = imem_addr;
      valid_nxt    = instr_valid;
      instr_nxt    = instr;
      instr_pc_nxt = instr_pc;
      epc_nxt      = epc;

      // The faulting instruction is the one held for decode in ISSUE;
      // otherwise it is the address currently (or last) being fetched.
      if (exception) begin
         epc_nxt = (state == ISSUE) ? instr_pc : imem_addr;
      end

      case (state)
         BOOT: begin
            pc_nxt    = flow_change ? target : pc;
            addr_nxt  = pc_nxt;
            valid_nxt = 1'b0;
            state_nxt = REQ;
         end

         REQ: begin
            if (imem_ack) begin
               if (flow_change) begin
                  // Returned word is on the wrong path: refetch at target.
                  pc_nxt   = target;
                  addr_nxt = target;
               end else begin
                  instr_nxt    = imem_rdata;
                  instr_pc_nxt = imem_addr;
                  pc_nxt       = pc + PC_INCR;
                  valid_nxt    = 1'b1;
                  state_nxt    = ISSUE;
               end
            end else if (flow_change) begin
               pc_nxt    = target;
               state_nxt = DRAIN;
            end
         end

         ISSUE: begin
            if (flow_change) begin
               valid_nxt = 1'b0;
               pc_nxt    = target;
               addr_nxt  = target;
               state_nxt = REQ;
            end else if (dec_ready && !stall) begin
               valid_nxt = 1'b0;
               addr_nxt  = pc;
               state_nxt = REQ;
            end
         end

         DRAIN: begin
            // Later flow changes only retarget the PC; the stale request
            // still has to be acked before the new fetch can go out.
            if (flow_change) begin
               pc_nxt = target;
            end
            if (imem_ack) begin
               addr_nxt  = pc_nxt;
               state_nxt = REQ;
            end
         end

         default: begin
            state_nxt = BOOT;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none

module tb_fetch_sequencer;

   localparam logic [31:0] RV = 32'h0000_0000;
   localparam logic [31:0] EV = 32'h0000_0180;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        dec_ready;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        exception;
   logic [31:0] epc;
   logic [31:0] pc;

   always #5 clock = ~clock;

   fetch_sequencer dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ack        (imem_ack),
      .imem_rdata      (imem_rdata),
      .instr_valid     (instr_valid),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .dec_ready       (dec_ready),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .exception       (exception),
      .epc             (epc),
      .pc              (pc)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Transaction-level reference: tracks whether a fetch is outstanding,
   // whether that fetch has been abandoned, and whether a word is being
   // offered to decode.
   // ---------------------------------------------------------------------
   bit          m_boot, m_out, m_dead, m_hold;
   logic [31:0] m_addr, m_pc, m_instr, m_ipc, m_epc;

   task automatic model_reset();
      m_boot = 1; m_out = 0; m_dead = 0; m_hold = 0;
      m_addr = 0; m_pc = RV; m_instr = 0; m_ipc = 0; m_epc = 0;
   endtask

   task automatic model_update();
      bit          evt;
      logic [31:0] t;
      evt = exception || redirect_valid;
      t   = exception ? EV : (redirect_target & 32'hFFFF_FFFC);
      if (exception) m_epc = m_hold ? m_ipc : m_addr;
      if (m_boot) begin
         m_boot = 0;
         if (evt) m_pc = t;
         m_out  = 1;
         m_addr = m_pc;
      end else if (m_hold) begin
         if (evt) begin
            m_hold = 0; m_pc = t; m_out = 1; m_addr = t;
         end else if (dec_ready && !stall) begin
            m_hold = 0; m_out = 1; m_addr = m_pc;
         end
      end else if (m_out && !m_dead) begin
         if (imem_ack) begin
            if (evt) begin
               m_pc = t; m_addr = t;
            end else begin
               m_instr = imem_rdata; m_ipc = m_addr; m_pc = m_pc + 4;
               m_hold = 1; m_out = 0;
            end
         end else if (evt) begin
            m_pc = t; m_dead = 1;
         end
      end else if (m_dead) begin
         if (evt) m_pc = t;
         if (imem_ack) begin
            m_dead = 0; m_addr = m_pc;
         end
      end
   endtask

   task automatic check_all();
      chk("imem_req",    {31'b0, imem_req},    {31'b0, m_out});
      chk("imem_addr",   imem_addr,            m_addr);
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_hold});
      chk("instr",       instr,                m_instr);
      chk("instr_pc",    instr_pc,             m_ipc);
      chk("epc",         epc,                  m_epc);
      chk("pc",          pc,                   m_pc);
   endtask

   // One clock: check outputs mid-cycle, apply inputs, advance the model.
   task automatic step(input bit a, input logic [31:0] rd, input bit dr, input bit st,
                       input bit rv, input logic [31:0] rt, input bit ex);
      @(negedge clock);
      check_all();
      imem_ack = a; imem_rdata = rd; dec_ready = dr; stall = st;
      redirect_valid = rv; redirect_target = rt; exception = ex;
      @(posedge clock);
      model_update();
   endtask

   task automatic reach_issue();
      for (int i = 0; i < 20 && !m_hold; i++) step(1, $urandom, 0, 0, 0, 0, 0);
      chk("reach_issue", {31'b0, m_hold}, 32'd1);
   endtask

   task automatic reach_req();
      for (int i = 0; i < 20 && !(m_out && !m_dead && !m_boot); i++)
         step(0, $urandom, 1, 0, 0, 0, 0);
      chk("reach_req", {31'b0, (m_out && !m_dead)}, 32'd1);
   endtask

   task automatic reset_now();
      #2 reset_n = 1'b0;
      #1;
      chk("rst_req",   {31'b0, imem_req},    32'd0);
      chk("rst_addr",  imem_addr,            32'd0);
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_instr", instr,                32'd0);
      chk("rst_ipc",   instr_pc,             32'd0);
      chk("rst_epc",   epc,                  32'd0);
      chk("rst_pc",    pc,                   RV);
      model_reset();
      imem_ack = 0; dec_ready = 0; stall = 0; redirect_valid = 0; exception = 0;
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      imem_ack = 0; imem_rdata = 0; dec_ready = 0; stall = 0;
      redirect_valid = 0; redirect_target = 0; exception = 0;
      model_reset();
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;

      // Back-to-back fetches, ack tied high and decode always ready.
      for (int i = 0; i < 8; i++) step(1, $urandom, 1, 0, 0, 0, 0);
      // Slow memory: three cycles without ack.
      reach_req();
      for (int i = 0; i < 3; i++) step(0, $urandom, 1, 0, 0, 0, 0);
      step(1, $urandom, 1, 0, 0, 0, 0);
      // Redirect in ISSUE with decode ready: no transfer, refetch at 0x200.
      reach_issue();
      step(0, 0, 1, 0, 1, 32'h0000_0203, 0);
      step(1, $urandom, 0, 0, 0, 0, 0);
      // Redirect while a fetch is pending: drained word must be dropped.
      reach_req();
      step(0, $urandom, 1, 0, 1, 32'h0000_0400, 0);
      step(0, $urandom, 1, 0, 0, 0, 0);
      step(1, 32'hDEAD_BEEF, 1, 0, 0, 0, 0);
      step(1, $urandom, 0, 0, 0, 0, 0);
      // Exception and redirect together in ISSUE: exception wins.
      reach_issue();
      step(0, 0, 1, 0, 1, 32'h0000_0400, 1);
      step(1, $urandom, 0, 1, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0, 0);
      // PC wrap at the top of the address space.
      reach_issue();
      step(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0);
      step(1, $urandom, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0, 0);
      #1;
      chk("wrap_addr", imem_addr, 32'h0000_0000);
      // Reset mid-request, then the fetch after release goes to the vector.
      reset_now();
      for (int i = 0; i < 4; i++) step(1, $urandom, 1, 0, 0, 0, 0);

      // Randomized run.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] rt;
         rt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
         if (i == 1500) reset_now();
         step($urandom_range(0, 1), $urandom, $urandom_range(0, 9) < 7,
              $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, rt,
              $urandom_range(0, 19) == 0);
      end
      @(negedge clock);
      check_all();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
